// File: rtl/memwrite_checker_pkg.sv
// Shared types and constants for the data-memory write checker.
package memwrite_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    PASS,
    FAIL,
    TIMEOUT
  } state_t;

  localparam logic MODE_UNORDERED = 1'b0;
  localparam logic MODE_ORDERED   = 1'b1;

  localparam int CNT_W = 16;

endpackage

// File: rtl/mwc_match_table.sv
// Expected (address, data) table with valid bits, plus the combinational
// address lookup that picks the lowest-index valid entry for a store.
module mwc_match_table
  import memwrite_checker_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_CHECKS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [ADDR_W-1:0]     probe_addr,
  input  logic [DATA_W-1:0]     probe_data,
  input  logic [NUM_CHECKS-1:0] hit_vec,
  output logic [NUM_CHECKS-1:0] valid,
  output logic                  match,
  output logic [IDX_W-1:0]      match_idx,
  output logic                  data_eq,
  output logic                  all_hit
);

  logic [ADDR_W-1:0]     addr_q [NUM_CHECKS];
  logic [DATA_W-1:0]     data_q [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] valid_q;

  // Indices at or beyond NUM_CHECKS never match any slot and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          addr_q[i]  <= wr_addr;
          data_q[i]  <= wr_data;
          valid_q[i] <= 1'b1;
        end
      end
    end
  end

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    data_eq   = 1'b0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (valid_q[i] && (addr_q[i] == probe_addr)) begin
        match     = 1'b1;
        match_idx = IDX_W'(i);
        data_eq   = (data_q[i] == probe_data);
      end
    end
  end

  assign all_hit = &(hit_vec | ~valid_q);
  assign valid   = valid_q;

endmodule

// File: rtl/memwrite_checker.sv
// Snoops the processor store port and checks stores against a small table
// of expected (address, data) pairs, reporting pass / fail / timeout.
//
//   state   | meaning
//   IDLE    | table writable, waiting for start
//   ARMED   | checking stores, timeout counter running
//   PASS    | every valid entry matched
//   FAIL    | data mismatch or out-of-order hit; diagnostics latched
//   TIMEOUT | timeout expired before completion
module memwrite_checker
  import memwrite_checker_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_CHECKS     = 4,
  parameter bit ORDERED        = MODE_UNORDERED,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic                  start,
  input  logic                  MemWrite,
  input  logic [ADDR_W-1:0]     DataAddr,
  input  logic [DATA_W-1:0]     WriteData,
  output logic                  armed,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [NUM_CHECKS-1:0] hit_mask,
  output logic [IDX_W-1:0]      fail_idx,
  output logic [DATA_W-1:0]     fail_data,
  output logic [CNT_W-1:0]      write_count
);

  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t                state_q, state_d;
  logic [NUM_CHECKS-1:0] hit_q, hit_set, hit_next, valid, match_oh;
  logic [CNT_W-1:0]      wcnt_q;
  logic [31:0]           tcnt_q;
  logic [IDX_W-1:0]      fail_idx_q, match_idx, ptr;
  logic [DATA_W-1:0]     fail_data_q;
  logic                  match, data_eq, all_hit;
  logic                  ptr_ok, at_ptr, watched_hit;
  logic                  arm_clear, do_fail, tmo_hit;

  mwc_match_table #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_CHECKS (NUM_CHECKS),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (cfg_we && (state_q == IDLE)),
    .wr_idx     (cfg_idx),
    .wr_addr    (cfg_addr),
    .wr_data    (cfg_data),
    .probe_addr (DataAddr),
    .probe_data (WriteData),
    .hit_vec    (hit_next),
    .valid      (valid),
    .match      (match),
    .match_idx  (match_idx),
    .data_eq    (data_eq),
    .all_hit    (all_hit)
  );

  // Ordered-mode pointer: lowest valid entry not yet hit.
  always_comb begin
    ptr_ok   = 1'b0;
    ptr      = '0;
    match_oh = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (valid[i] && !hit_q[i]) begin
        ptr_ok = 1'b1;
        ptr    = IDX_W'(i);
      end
      match_oh[i] = match && (match_idx == IDX_W'(i));
    end
  end

  assign at_ptr      = ptr_ok && (match_idx == ptr);
  assign watched_hit = |(match_oh & hit_q);
  assign tmo_hit     = (TIMEOUT_CYCLES > 0) && (tcnt_q == TO_LAST);

  // Store evaluation kept apart from next-state so all_hit can see hit_next.
  always_comb begin
    hit_set = '0;
    do_fail = 1'b0;
    if ((state_q == ARMED) && MemWrite && match) begin
      if (ORDERED == MODE_ORDERED) begin
        if (data_eq && at_ptr) hit_set = match_oh;
        else if (!(data_eq && watched_hit)) do_fail = 1'b1;
      end else begin
        if (data_eq) hit_set = match_oh;
        else do_fail = 1'b1;
      end
    end
  end

  assign hit_next = hit_q | hit_set;

  always_comb begin
    state_d   = state_q;
    arm_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ARMED;
          arm_clear = 1'b1;
        end
      end
      ARMED: begin
        if (do_fail)      state_d = FAIL;
        else if (all_hit) state_d = PASS;
        else if (tmo_hit) state_d = TIMEOUT;
      end
      PASS, FAIL, TIMEOUT: begin
        if (start) begin
          state_d   = ARMED;
          arm_clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q       <= '0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      fail_idx_q  <= '0;
      fail_data_q <= '0;
    end else begin
      if (arm_clear) begin
        hit_q  <= '0;
        wcnt_q <= '0;
        tcnt_q <= '0;
      end else if (state_q == ARMED) begin
        hit_q  <= hit_next;
        tcnt_q <= tcnt_q + 32'd1;
        if (MemWrite && (wcnt_q != '1)) wcnt_q <= wcnt_q + CNT_W'(1);
      end
      if (do_fail) begin
        fail_idx_q  <= match_idx;
        fail_data_q <= WriteData;
      end
    end
  end

  assign armed       = (state_q == ARMED);
  assign pass        = (state_q == PASS);
  assign fail        = (state_q == FAIL);
  assign timeout     = (state_q == TIMEOUT);
  assign done        = pass || fail || timeout;
  assign hit_mask    = hit_q;
  assign fail_idx    = fail_idx_q;
  assign fail_data   = fail_data_q;
  assign write_count = wcnt_q;

endmodule

// File: tb/tb_memwrite_checker.sv
// Bench for memwrite_checker: an unordered and an ordered instance share one
// stimulus stream and are compared every cycle against a table-level model.
module tb_memwrite_checker;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int IW = 2;
  localparam int TO = 20;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_PASS  = 2;
  localparam int M_FAIL  = 3;
  localparam int M_TMO   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cfg_we, start, mem_write;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_addr, data_addr;
  logic [DW-1:0] cfg_data, write_data;

  logic [1:0]           armed_o, done_o, pass_o, fail_o, timeout_o;
  logic [1:0][NC-1:0]   hit_o;
  logic [1:0][IW-1:0]   fidx_o;
  logic [1:0][DW-1:0]   fdata_o;
  logic [1:0][15:0]     wcnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 = unordered, 1 = ordered.
  int          m_st    [2];
  bit [AW-1:0] m_addr  [2][NC];
  bit [DW-1:0] m_data  [2][NC];
  bit [NC-1:0] m_valid [2];
  bit [NC-1:0] m_hit   [2];
  int          m_wc    [2];
  int          m_age   [2];
  int          m_fidx  [2];
  bit [DW-1:0] m_fdata [2];

  int unsigned pool [4] = '{80, 84, 96, 100};

  memwrite_checker #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .ORDERED(1'b0), .TIMEOUT_CYCLES(TO)
  ) u_unord (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .MemWrite(mem_write), .DataAddr(data_addr),
    .WriteData(write_data), .armed(armed_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .fail(fail_o[0]), .timeout(timeout_o[0]), .hit_mask(hit_o[0]), .fail_idx(fidx_o[0]),
    .fail_data(fdata_o[0]), .write_count(wcnt_o[0])
  );

  memwrite_checker #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .ORDERED(1'b1), .TIMEOUT_CYCLES(TO)
  ) u_ord (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .MemWrite(mem_write), .DataAddr(data_addr),
    .WriteData(write_data), .armed(armed_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .fail(fail_o[1]), .timeout(timeout_o[1]), .hit_mask(hit_o[1]), .fail_idx(fidx_o[1]),
    .fail_data(fdata_o[1]), .write_count(wcnt_o[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_arm(input int m);
    m_st[m]  = M_ARMED;
    m_hit[m] = '0;
    m_wc[m]  = 0;
    m_age[m] = 0;
  endtask

  task automatic model_step(input int m);
    int w, p;
    bit bad, eq;
    bit [NC-1:0] nh;
    if (rst) begin
      m_st[m] = M_IDLE; m_valid[m] = '0; m_hit[m] = '0; m_wc[m] = 0;
      m_age[m] = 0; m_fidx[m] = 0; m_fdata[m] = '0;
      return;
    end
    case (m_st[m])
      M_IDLE: begin
        if (cfg_we) begin
          m_addr[m][cfg_idx]  = cfg_addr;
          m_data[m][cfg_idx]  = cfg_data;
          m_valid[m][cfg_idx] = 1'b1;
        end
        if (start) model_arm(m);
      end
      M_ARMED: begin
        bad = 1'b0;
        nh  = m_hit[m];
        w   = -1;
        if (mem_write) begin
          if (m_wc[m] < 65535) m_wc[m]++;
          for (int i = 0; i < NC; i++)
            if (w < 0 && m_valid[m][i] && m_addr[m][i] == data_addr) w = i;
          if (w >= 0) begin
            eq = (m_data[m][w] == write_data);
            if (m == 0) begin
              if (eq) nh[w] = 1'b1; else bad = 1'b1;
            end else begin
              p = -1;
              for (int i = 0; i < NC; i++)
                if (p < 0 && m_valid[m][i] && !m_hit[m][i]) p = i;
              if (eq && w == p) nh[w] = 1'b1;
              else if (!(eq && m_hit[m][w])) bad = 1'b1;
            end
          end
        end
        if (bad) begin
          m_st[m] = M_FAIL; m_fidx[m] = w; m_fdata[m] = write_data;
        end else begin
          m_hit[m] = nh;
          if ((m_valid[m] & ~nh) == '0) m_st[m] = M_PASS;
          else if (m_age[m] == TO - 1)  m_st[m] = M_TMO;
        end
        m_age[m]++;
      end
      default: if (start) model_arm(m);
    endcase
  endtask

  task automatic compare_all();
    logic [4:0] es, os;
    for (int m = 0; m < 2; m++) begin
      es = {m_st[m] == M_ARMED, m_st[m] >= M_PASS, m_st[m] == M_PASS,
            m_st[m] == M_FAIL, m_st[m] == M_TMO};
      os = {armed_o[m], done_o[m], pass_o[m], fail_o[m], timeout_o[m]};
      check_val($sformatf("u%0d.status", m), 32'(os), 32'(es));
      check_val($sformatf("u%0d.hit_mask", m), 32'(hit_o[m]), 32'(m_hit[m]));
      check_val($sformatf("u%0d.write_count", m), 32'(wcnt_o[m]), 32'(m_wc[m]));
      check_val($sformatf("u%0d.fail_idx", m), 32'(fidx_o[m]), 32'(m_fidx[m]));
      check_val($sformatf("u%0d.fail_data", m), fdata_o[m], m_fdata[m]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 0; cfg_we = 0; start = 0; mem_write = 0;
    cfg_idx = '0; cfg_addr = '0; cfg_data = '0; data_addr = '0; write_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic do_cfg(input int idx, input int unsigned a, input int unsigned d);
    cfg_we = 1; cfg_idx = IW'(idx); cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic do_arm();
    start = 1; tick(); start = 0;
  endtask

  task automatic do_store(input int unsigned a, input int unsigned d);
    mem_write = 1; data_addr = a; write_data = d;
    tick();
    mem_write = 0;
  endtask

  initial begin
    int n, k;
    for (int m = 0; m < 2; m++) begin
      m_st[m] = M_IDLE; m_valid[m] = '0; m_hit[m] = '0; m_wc[m] = 0;
      m_age[m] = 0; m_fidx[m] = 0; m_fdata[m] = '0;
    end
    idle_inputs();
    repeat (2) @(posedge clk);

    // Reset state.
    do_reset();
    check_val("reset.status", 32'({armed_o[0], done_o[0], pass_o[0], fail_o[0], timeout_o[0]}), 32'd0);
    check_val("reset.write_count", 32'(wcnt_o[1]), 32'd0);

    // Classic single expected store.
    do_cfg(0, 100, 7);
    do_arm();
    do_store(96, 5);
    check_val("classic.pass_early", 32'(pass_o[0]), 32'd0);
    do_store(100, 7);
    check_val("classic.pass", 32'(pass_o[0]), 32'd1);
    check_val("classic.hit_mask", 32'(hit_o[0]), 32'd1);
    check_val("classic.write_count", 32'(wcnt_o[0]), 32'd2);

    // Data mismatch.
    do_reset();
    do_cfg(0, 100, 7);
    do_arm();
    do_store(100, 9);
    check_val("mismatch.fail", 32'(fail_o[0]), 32'd1);
    check_val("mismatch.fail_idx", 32'(fidx_o[0]), 32'd0);
    check_val("mismatch.fail_data", fdata_o[0], 32'd9);
    check_val("mismatch.pass", 32'(pass_o[0]), 32'd0);

    // Ordered violation, then re-arm and complete in order.
    do_reset();
    do_cfg(0, 80, 1);
    do_cfg(1, 84, 2);
    do_arm();
    do_store(84, 2);
    check_val("ordered.fail", 32'(fail_o[1]), 32'd1);
    check_val("ordered.fail_idx", 32'(fidx_o[1]), 32'd1);
    check_val("unordered.still_armed", 32'(armed_o[0]), 32'd1);
    do_arm();
    do_store(80, 1);
    do_store(84, 2);
    check_val("ordered.pass", 32'(pass_o[1]), 32'd1);
    check_val("ordered.hit_mask", 32'(hit_o[1]), 32'd3);

    // Timeout exactly TO cycles after arming, and completion on the last cycle.
    do_reset();
    do_cfg(0, 100, 7);
    do_arm();
    repeat (TO - 1) tick();
    check_val("timeout.before", 32'(timeout_o[0]), 32'd0);
    check_val("timeout.armed", 32'(armed_o[0]), 32'd1);
    tick();
    check_val("timeout.expired", 32'(timeout_o[0]), 32'd1);
    do_reset();
    do_cfg(0, 100, 7);
    do_arm();
    repeat (TO - 1) tick();
    do_store(100, 7);
    check_val("timeout.last_pass", 32'(pass_o[0]), 32'd1);
    check_val("timeout.last_tmo", 32'(timeout_o[0]), 32'd0);

    // Reset while armed clears everything including the table.
    do_reset();
    do_cfg(0, 100, 7);
    do_arm();
    do_store(96, 5);
    do_reset();
    check_val("midrst.status", 32'({armed_o[1], done_o[1], pass_o[1], fail_o[1], timeout_o[1]}), 32'd0);
    check_val("midrst.write_count", 32'(wcnt_o[0]), 32'd0);
    do_arm();
    check_val("empty.armed", 32'(armed_o[0]), 32'd1);
    tick();
    check_val("empty.pass", 32'(pass_o[0]), 32'd1);

    // Config writes while armed are ignored.
    do_reset();
    do_cfg(0, 100, 7);
    do_arm();
    do_cfg(1, 200, 3);
    do_store(100, 7);
    check_val("cfg_armed.pass", 32'(pass_o[1]), 32'd1);
    do_arm();
    do_store(100, 7);
    check_val("cfg_armed.rearm_pass", 32'(pass_o[0]), 32'd1);
    check_val("cfg_armed.hit_mask", 32'(hit_o[0]), 32'd1);

    // Config and start on the same cycle.
    do_reset();
    cfg_we = 1; cfg_idx = 2'd3; cfg_addr = 104; cfg_data = 4; start = 1;
    tick();
    idle_inputs();
    tick();
    check_val("cfg_start.armed", 32'(armed_o[0]), 32'd1);

    // Randomized sessions.
    for (int it = 0; it < 50; it++) begin
      do_reset();
      n = $urandom_range(0, 5);
      for (int c = 0; c < n; c++) begin
        cfg_we = 1; cfg_idx = IW'($urandom_range(0, NC - 1));
        cfg_addr = pool[$urandom_range(0, 3)]; cfg_data = $urandom_range(0, 3);
        start = (c == n - 1) && ($urandom_range(0, 1) == 1);
        tick();
      end
      idle_inputs();
      if (m_st[0] == M_IDLE) do_arm();
      for (int cyc = 0; cyc < 30; cyc++) begin
        mem_write = ($urandom_range(0, 9) < 6);
        k = $urandom_range(0, NC - 1);
        if (m_valid[0][k] && $urandom_range(0, 3) != 0) begin
          data_addr  = m_addr[0][k];
          write_data = ($urandom_range(0, 3) != 0) ? m_data[0][k] : DW'($urandom_range(0, 3));
        end else begin
          data_addr  = pool[$urandom_range(0, 3)];
          write_data = DW'($urandom_range(0, 3));
        end
        cfg_we   = ($urandom_range(0, 9) == 0);
        cfg_idx  = IW'($urandom_range(0, NC - 1));
        cfg_addr = pool[$urandom_range(0, 3)];
        cfg_data = DW'($urandom_range(0, 3));
        start    = ($urandom_range(0, 19) == 0);
        rst      = ($urandom_range(0, 49) == 0);
        tick();
      end
      idle_inputs();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
